dm_access_unit: RTL and testbench

//  Load/store unit with a latched, multi-cycle data-memory port. Sits directly downstream of the datapath.

---
 rtl/dm_pkg.sv | 29 ++
 rtl/dm_load_align.sv | 29 ++
 rtl/dm_access_unit.sv | 157 +++++++++++++++
 tb/tb_dm_access_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access unit: f3 access codes and FSM states.
// The misalignment helper is only referenced when DM_MISALIGN_CHECK_EN is defined.
package dm_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Half accesses need an even offset, word accesses need offset 0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] byte_off);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = byte_off[0];
            F3_W:        mis = (byte_off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Selects the addressed byte/half from a raw memory word and sign- or zero-extends it per f3.
// Unsupported f3 codes produce zero.
module dm_load_align
    import dm_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  f3,
    input  logic [1:0]  byte_off,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? raw[31:16] : raw[15:0];
        rdata    = 32'h0;
        case (f3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_BU:   rdata = {24'h0, byte_sel};
            F3_HU:   rdata = {16'h0, half_sel};
            F3_W:    rdata = raw;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store unit with a LAT-cycle latched data-memory port; stalls the PC while busy.
// Optional DM_MISALIGN_CHECK_EN: flags misaligned half/word accesses on err and suppresses them.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        f3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        byte_off,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem [DEPTH];
    logic              access;
    logic              mis;
    logic [3:0]        be;
    logic [31:0]       wlanes;
    logic [31:0]       load_val;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        done    = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = req;
                if (req) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LAT - 1);
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                // req belongs to the retiring instruction here, so it is not re-accepted.
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef DM_MISALIGN_CHECK_EN
    assign mis = is_misaligned(f3_q, off_q);
`else
    assign mis = 1'b0;
`endif

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be     = 4'b0000;
        wlanes = wdata_q;
        case (f3_q)
            F3_B: begin
                be     = 4'b0001 << off_q;
                wlanes = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                be     = off_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!we_q || mis) begin
            be = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && req) begin
                we_q    <= we;
                f3_q    <= f3;
                addr_q  <= addr;
                off_q   <= byte_off;
                wdata_q <= wdata;
            end
            if (access && (!we_q || mis)) begin
                rdata_q <= mis ? 32'h0 : load_val;
            end
        end
    end

    // No reset on the array; a reset coinciding with the access edge drops the store.
    always_ff @(posedge clk) begin
        if (access && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr_q][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    dm_load_align u_load_align (
        .raw      (mem[addr_q]),
        .f3       (f3_q),
        .byte_off (off_q),
        .rdata    (load_val)
    );

    assign rdata = rdata_q;

`ifdef DM_MISALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access && mis;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed cases plus random loads/stores against a word-array model.
// Three instances cover LAT=2 (main), LAT=1 and LAT=15.
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic        we;
    logic [2:0]  f3;
    logic [4:0]  addr;
    logic [1:0]  byte_off;
    logic [31:0] wdata;
    logic [31:0] rdata_v [3];
    logic [2:0]  stall;
    logic [2:0]  done;
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mmem [3][32];
    logic [31:0] mrd  [3];

    always #5 clk = ~clk;

    dm_access_unit #(.ADDR_W(5), .LAT(2)) dut (
        .clk(clk), .reset(reset), .req(req[0]), .we(we), .f3(f3), .addr(addr),
        .byte_off(byte_off), .wdata(wdata), .rdata(rdata_v[0]), .stall(stall[0]),
        .done(done[0]), .err(err[0])
    );

    dm_access_unit #(.ADDR_W(5), .LAT(1)) dut_lat1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we), .f3(f3), .addr(addr),
        .byte_off(byte_off), .wdata(wdata), .rdata(rdata_v[1]), .stall(stall[1]),
        .done(done[1]), .err(err[1])
    );

    dm_access_unit #(.ADDR_W(5), .LAT(15)) dut_lat15 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we), .f3(f3), .addr(addr),
        .byte_off(byte_off), .wdata(wdata), .rdata(rdata_v[2]), .stall(stall[2]),
        .done(done[2]), .err(err[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 2 : (sel == 1) ? 1 : 15;
    endfunction

    function automatic logic model_mis(input logic [2:0] f, input logic [1:0] o);
`ifdef DM_MISALIGN_CHECK_EN
        return ((f == 3'd1 || f == 3'd5) && o[0]) || (f == 3'd2 && o != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f,
                                               input logic [1:0] o);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * int'(o)));
        h = 16'(word >> (16 * int'(o[1])));
        case (f)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            3'd2:    return word;
            default: return 32'h0;
        endcase
    endfunction

    // Runs one access on instance sel and checks timing, stall, rdata and err against the model.
    task automatic access(input int sel, input bit w, input logic [2:0] f, input logic [4:0] a,
                          input logic [1:0] o, input logic [31:0] d, input bit drop);
        int          lat;
        int          k;
        int          st;
        bit          got;
        bit          mis;
        logic [31:0] tmp;
        lat = lat_of(sel);
        mis = model_mis(f, o);
        if (!w || mis) begin
            mrd[sel] = mis ? 32'h0 : model_load(mmem[sel][a], f, o);
        end else if (f <= 3'd2) begin
            tmp = mmem[sel][a];
            for (int i = 0; i < 4; i++) begin
                if (f == 3'd2) tmp[8*i +: 8] = d[8*i +: 8];
                else if (f == 3'd1 && (i / 2) == int'(o[1])) tmp[8*i +: 8] = d[8*(i%2) +: 8];
                else if (f == 3'd0 && i == int'(o)) tmp[8*i +: 8] = d[7:0];
            end
            mmem[sel][a] = tmp;
        end
        @(negedge clk);
        we = w; f3 = f; addr = a; byte_off = o; wdata = d; req[sel] = 1'b1;
        #1;
        check("stall_on_req", 32'(stall[sel]), 32'd1);
        st = 1; k = 0; got = 0;
        while (k < 40 && !got) begin
            @(negedge clk);
            k++;
            if (drop && k == 1) req[sel] = 1'b0;
            if (done[sel]) got = 1;
            else st += int'(stall[sel]);
        end
        req[sel] = 1'b0;
        check("done_latency", got ? 32'(k) : 32'hFFFF_FFFF, 32'(lat + 1));
        check("stall_cycles", 32'(st), 32'(lat + 1));
        check("stall_at_done", 32'(stall[sel]), 32'd0);
        check("rdata", rdata_v[sel], mrd[sel]);
        check("err_with_done", 32'(err[sel]), 32'(mis));
        @(negedge clk);
        check("done_one_cycle", 32'({done[sel], err[sel]}), 32'd0);
    endtask

    initial begin
        int cnt;
        bit w;
        logic [2:0] f;
        reset = 1'b1; req = 3'b000; we = 1'b0; f3 = 3'd0; addr = 5'd0;
        byte_off = 2'd0; wdata = 32'h0;
        for (int s = 0; s < 3; s++) mrd[s] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata_v[0], 32'h0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) access(0, 1, 3'd2, 5'(i), 2'd0, $urandom, 0);

        // Directed cases
        access(0, 1, 3'd2, 5'd3, 2'd0, 32'h1122_3344, 0);
        access(0, 0, 3'd2, 5'd3, 2'd0, 32'h0, 0);
        check("lw_addr3", rdata_v[0], 32'h1122_3344);
        access(0, 1, 3'd0, 5'd3, 2'd1, 32'h0000_00A5, 0);
        access(0, 0, 3'd2, 5'd3, 2'd0, 32'h0, 0);
        check("lw_after_sb", rdata_v[0], 32'h1122_A544);
        access(0, 0, 3'd0, 5'd3, 2'd1, 32'h0, 0);
        check("lb_off1", rdata_v[0], 32'hFFFF_FFA5);
        access(0, 0, 3'd4, 5'd3, 2'd1, 32'h0, 0);
        check("lbu_off1", rdata_v[0], 32'h0000_00A5);
        access(0, 1, 3'd2, 5'd7, 2'd0, 32'h8001_7FFF, 0);
        access(0, 0, 3'd1, 5'd7, 2'd2, 32'h0, 0);
        check("lh_off2", rdata_v[0], 32'hFFFF_8001);
        access(0, 0, 3'd5, 5'd7, 2'd2, 32'h0, 0);
        check("lhu_off2", rdata_v[0], 32'h0000_8001);
        access(0, 0, 3'd1, 5'd7, 2'd0, 32'h0, 0);
        check("lh_off0", rdata_v[0], 32'h0000_7FFF);
        access(0, 0, 3'd3, 5'd7, 2'd0, 32'h0, 0);
        check("invalid_f3_zero", rdata_v[0], 32'h0);
        access(0, 1, 3'd2, 5'd9, 2'd0, 32'hCAFE_F00D, 1);
        access(0, 0, 3'd2, 5'd9, 2'd0, 32'h0, 0);
        check("req_drop_store", rdata_v[0], 32'hCAFE_F00D);
        access(0, 0, 3'd2, 5'd3, 2'd1, 32'h0, 0);
`ifdef DM_MISALIGN_CHECK_EN
        check("lw_misaligned", rdata_v[0], 32'h0);
`else
        check("lw_off1_word", rdata_v[0], 32'h1122_A544);
`endif

        // Reset in the first WAIT cycle aborts a store to addr 5
        @(negedge clk);
        we = 1'b1; f3 = 3'd2; addr = 5'd5; byte_off = 2'd0; wdata = 32'hDEAD_BEEF; req[0] = 1'b1;
        @(negedge clk);
        reset = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) mrd[s] = 32'h0;
        check("abort_stall", 32'(stall[0]), 32'd0);
        check("abort_rdata", rdata_v[0], 32'h0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(done[0]);
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        access(0, 0, 3'd2, 5'd5, 2'd0, 32'h0, 0);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            f = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            access(0, w, f, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom, 0);
        end

        // Latency extremes
        for (int s = 1; s < 3; s++) begin
            access(s, 1, 3'd2, 5'd0, 2'd0, 32'h0BAD_CAFE + 32'(s), 0);
            access(s, 0, 3'd2, 5'd0, 2'd0, 32'h0, 0);
            check("lat_rdata", rdata_v[s], 32'h0BAD_CAFE + 32'(s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
